// File: rtl/sram_responder_if.sv
// Control side of the asynchronous-SRAM-style bus: address and the three active-low strobes.
// The shared data bus stays a plain inout on the responder because it is bidirectional.
interface sram_responder_if;
   logic [17:0] memAddrBus;
   logic        memRead;
   logic        memWrite;
   logic        memEnable;

   modport master (output memAddrBus, output memRead, output memWrite, output memEnable);
   modport slave  (input  memAddrBus, input  memRead, input  memWrite, input  memEnable);
endinterface

// File: rtl/sram_responder.sv
// Clocked SRAM responder: samples the controller strobes every edge, answers reads after a
// programmable latency on a tri-stated data bus, commits writes, and keeps access counters.
module sram_responder #(
   parameter int DEPTH_LOG2 = 10,
   parameter int READ_LAT   = 2
) (
   input  logic              clk,
   input  logic              rst,
   sram_responder_if.slave   ctrl,
   inout  wire  [15:0]       memDataBus,
   output logic              busDrive,
   output logic              errFlag,
   output logic [15:0]       rdCount,
   output logic [15:0]       wrCount
);

   typedef enum logic [1:0] {IDLE, RD_WAIT, RD_DRIVE, WRITE} state_t;

   localparam int         DEPTH    = 1 << DEPTH_LOG2;
   localparam logic [2:0] LAT_LOAD = 3'(READ_LAT - 1);

   state_t      state_q, state_d;
   logic [17:0] addr_q, addr_d;
   logic [2:0]  cnt_q, cnt_d;
   logic        err_q, err_d;
   logic [15:0] rd_cnt_q, rd_cnt_d;
   logic [15:0] wr_cnt_q, wr_cnt_d;
   logic [15:0] rd_data_q;
   logic [15:0] mem [DEPTH];

   logic        wr_cmd;
   logic        rd_cmd;
   logic        drive_enter;

   always_comb begin
      wr_cmd      = !ctrl.memEnable && !ctrl.memWrite;
      rd_cmd      = !ctrl.memEnable && !ctrl.memRead && ctrl.memWrite;
      state_d     = state_q;
      addr_d      = addr_q;
      cnt_d       = cnt_q;
      err_d       = err_q;
      rd_cnt_d    = rd_cnt_q;
      wr_cnt_d    = wr_cnt_q;
      drive_enter = 1'b0;

      if (wr_cmd) begin
         // Write wins over a simultaneous read strobe; that overlap is a protocol error.
         state_d  = WRITE;
         wr_cnt_d = wr_cnt_q + 16'd1;
         if (!ctrl.memRead) begin
            err_d = 1'b1;
         end
      end else if (rd_cmd) begin
         if (state_q == IDLE || state_q == WRITE || ctrl.memAddrBus != addr_q) begin
            addr_d = ctrl.memAddrBus;
            if (READ_LAT == 1) begin
               state_d     = RD_DRIVE;
               drive_enter = 1'b1;
            end else begin
               state_d = RD_WAIT;
               cnt_d   = LAT_LOAD;
            end
         end else if (state_q == RD_WAIT) begin
            // The edge that takes the counter to zero is the one that starts driving.
            if (cnt_q <= 3'd1) begin
               state_d     = RD_DRIVE;
               drive_enter = 1'b1;
               cnt_d       = 3'd0;
            end else begin
               cnt_d = cnt_q - 3'd1;
            end
         end
      end else begin
         state_d = IDLE;
      end

      if (drive_enter) begin
         rd_cnt_d = rd_cnt_q + 16'd1;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q  <= IDLE;
         addr_q   <= '0;
         cnt_q    <= '0;
         err_q    <= 1'b0;
         rd_cnt_q <= '0;
         wr_cnt_q <= '0;
      end else begin
         state_q  <= state_d;
         addr_q   <= addr_d;
         cnt_q    <= cnt_d;
         err_q    <= err_d;
         rd_cnt_q <= rd_cnt_d;
         wr_cnt_q <= wr_cnt_d;
      end
   end

   // Array contents survive reset; reset only blocks a commit on an edge it overlaps.
   always_ff @(posedge clk or negedge rst) begin
      if (rst) begin
         if (wr_cmd) begin
            mem[ctrl.memAddrBus[DEPTH_LOG2-1:0]] <= memDataBus;
         end
         if (drive_enter) begin
            rd_data_q <= mem[addr_d[DEPTH_LOG2-1:0]];
         end
      end
   end

   assign busDrive   = (state_q == RD_DRIVE);
   assign errFlag    = err_q;
   assign rdCount    = rd_cnt_q;
   assign wrCount    = wr_cnt_q;
   assign memDataBus = busDrive ? rd_data_q : 16'hzzzz;

endmodule

// File: tb/tb_sram_responder.sv
// Scoreboard bench: each read pushes its expected word and arrival cycle; a monitor pops on
// every rdCount step. A second READ_LAT=1 instance covers direct drive and counter wrap.
`timescale 1ns/1ps
module tb_sram_responder;
   localparam int LAT = 2;
   localparam int DL2 = 10;

   typedef struct {
      logic [15:0] data;
      int          cyc;
   } exp_t;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst, rst2;
   logic        drv1, drv2;
   logic [15:0] wdat1, wdat2;
   wire  [15:0] data1, data2;
   logic        bd1, err1, bd2, err2;
   logic [15:0] rdc1, wrc1, rdc2, wrc2;

   sram_responder_if bus1 ();
   sram_responder_if bus2 ();

   assign data1 = drv1 ? wdat1 : 16'hzzzz;
   assign data2 = drv2 ? wdat2 : 16'hzzzz;

   sram_responder #(.DEPTH_LOG2(DL2), .READ_LAT(LAT)) dut (
      .clk(clk), .rst(rst), .ctrl(bus1), .memDataBus(data1),
      .busDrive(bd1), .errFlag(err1), .rdCount(rdc1), .wrCount(wrc1)
   );

   sram_responder #(.DEPTH_LOG2(DL2), .READ_LAT(1)) dut_lat1 (
      .clk(clk), .rst(rst2), .ctrl(bus2), .memDataBus(data2),
      .busDrive(bd2), .errFlag(err2), .rdCount(rdc2), .wrCount(wrc2)
   );

   int          vectors     = 0;
   int          miscompares = 0;
   int          cyc         = 0;
   exp_t        sb_q[$];
   logic [15:0] model [int];
   logic [15:0] rdc_prev = 16'd0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
      vectors++;
      if (got !== exp) begin
         miscompares++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
      end else begin
         $display("ok   %s: 0x%0h", tag, got);
      end
   endtask

   // Every step of rdCount is one entry into the drive state: pop and compare.
   always @(negedge clk) begin
      exp_t e;
      if (rst && rdc1 != rdc_prev) begin
         if (sb_q.size() == 0) begin
            check_value("sb_unexpected_read", 32'd1, 32'd0);
         end else begin
            e = sb_q.pop_front();
            check_value("rd_data", {16'd0, data1}, {16'd0, e.data});
            check_value("rd_latency_cycle", cyc, e.cyc);
         end
      end
      rdc_prev = rdc1;
   end

   task automatic idle_cycle();
      bus1.memEnable = 1'b1;
      bus1.memRead   = 1'b1;
      bus1.memWrite  = 1'b1;
      drv1           = 1'b0;
      @(negedge clk);
   endtask

   task automatic write_word(input logic [17:0] a, input logic [15:0] d);
      bus1.memEnable  = 1'b0;
      bus1.memWrite   = 1'b0;
      bus1.memRead    = 1'b1;
      bus1.memAddrBus = a;
      drv1            = 1'b1;
      wdat1           = d;
      model[int'(a[DL2-1:0])] = d;
      @(negedge clk);
      drv1 = 1'b0;
   endtask

   // Issues (or re-targets) a read and walks it to the first driven cycle.
   task automatic start_read(input logic [17:0] a);
      exp_t e;
      bus1.memEnable  = 1'b0;
      bus1.memRead    = 1'b0;
      bus1.memWrite   = 1'b1;
      bus1.memAddrBus = a;
      drv1            = 1'b0;
      e.data = model[int'(a[DL2-1:0])];
      e.cyc  = cyc + LAT;
      sb_q.push_back(e);
      for (int i = 0; i < LAT - 1; i++) begin
         @(negedge clk);
         check_value("rd_wait_hiz", {31'd0, bd1}, 32'd0);
      end
      @(negedge clk);
      check_value("rd_drive", {31'd0, bd1}, 32'd1);
   endtask

   task automatic read_word(input logic [17:0] a);
      start_read(a);
      idle_cycle();
      check_value("rd_release", {31'd0, bd1}, 32'd0);
   endtask

   initial begin
      logic [17:0] addrs [6];
      logic [15:0] r0, w0;

      rst = 1'b1; rst2 = 1'b1; drv1 = 1'b0; drv2 = 1'b0; wdat1 = '0; wdat2 = '0;
      bus1.memEnable = 1'b1; bus1.memRead = 1'b1; bus1.memWrite = 1'b1; bus1.memAddrBus = '0;
      bus2.memEnable = 1'b1; bus2.memRead = 1'b1; bus2.memWrite = 1'b1; bus2.memAddrBus = '0;
      #1 rst = 1'b0; rst2 = 1'b0;
      repeat (3) @(negedge clk);
      check_value("reset_busDrive", {31'd0, bd1}, 32'd0);
      check_value("reset_errFlag", {31'd0, err1}, 32'd0);
      check_value("reset_rdCount", {16'd0, rdc1}, 32'd0);
      check_value("reset_wrCount", {16'd0, wrc1}, 32'd0);
      rst = 1'b1;
      @(negedge clk);

      // Basic write then read.
      write_word(18'h00005, 16'hBEEF);
      idle_cycle();
      check_value("first_wrCount", {16'd0, wrc1}, 32'd1);
      read_word(18'h00005);
      check_value("first_rdCount", {16'd0, rdc1}, 32'd1);
      check_value("first_wrCount_after_rd", {16'd0, wrc1}, 32'd1);

      // Upper address bits alias.
      write_word(18'h00005, 16'h1234);
      idle_cycle();
      read_word(18'h00405);

      // Back-to-back writes, then readback.
      for (int i = 0; i < 6; i++) begin
         addrs[i] = 18'(32'h100 + i * 37 + $urandom_range(0, 20) * 1024);
         write_word(addrs[i], 16'($urandom));
      end
      idle_cycle();
      for (int i = 0; i < 6; i++) read_word(addrs[i]);

      // Read request directly from the write state.
      write_word(18'h003FF, 16'h7E57);
      read_word(18'h003FF);

      // Address change while driving restarts the latency and counts a new entry.
      write_word(18'h00010, 16'h1010);
      write_word(18'h00011, 16'h1111);
      idle_cycle();
      r0 = rdc1;
      start_read(18'h00010);
      start_read(18'h00011);
      check_value("addr_change_rdCount", {16'd0, rdc1}, {16'd0, r0 + 16'd2});
      idle_cycle();
      check_value("addr_change_release", {31'd0, bd1}, 32'd0);

      // Read and write strobes together: treated as a write, flagged, bus never driven.
      w0 = wrc1;
      bus1.memEnable = 1'b0; bus1.memRead = 1'b0; bus1.memWrite = 1'b0;
      bus1.memAddrBus = 18'h00020; drv1 = 1'b1; wdat1 = 16'hA5A5;
      model[32'h20] = 16'hA5A5;
      @(negedge clk);
      check_value("err_no_drive", {31'd0, bd1}, 32'd0);
      check_value("err_set", {31'd0, err1}, 32'd1);
      check_value("err_wrCount", {16'd0, wrc1}, {16'd0, w0 + 16'd1});
      repeat (3) idle_cycle();
      check_value("err_sticky", {31'd0, err1}, 32'd1);
      read_word(18'h00020);

      // Chip disabled: strobes are ignored.
      r0 = rdc1; w0 = wrc1;
      bus1.memEnable = 1'b1; bus1.memRead = 1'b0; bus1.memWrite = 1'b0;
      bus1.memAddrBus = 18'h00005; drv1 = 1'b1; wdat1 = 16'hFFFF;
      repeat (3) @(negedge clk);
      drv1 = 1'b0;
      check_value("disabled_wrCount", {16'd0, wrc1}, {16'd0, w0});
      check_value("disabled_rdCount", {16'd0, rdc1}, {16'd0, r0});
      check_value("disabled_busDrive", {31'd0, bd1}, 32'd0);
      idle_cycle();
      read_word(18'h00005);

      // Asynchronous reset mid-drive; a write overlapping reset is dropped.
      start_read(18'h00005);
      #2 rst = 1'b0;
      #1;
      check_value("async_rst_busDrive", {31'd0, bd1}, 32'd0);
      check_value("async_rst_errFlag", {31'd0, err1}, 32'd0);
      check_value("async_rst_rdCount", {16'd0, rdc1}, 32'd0);
      check_value("async_rst_wrCount", {16'd0, wrc1}, 32'd0);
      @(negedge clk);
      bus1.memEnable = 1'b0; bus1.memRead = 1'b1; bus1.memWrite = 1'b0;
      bus1.memAddrBus = 18'h00005; drv1 = 1'b1; wdat1 = 16'hDEAD;
      @(negedge clk);
      idle_cycle();
      rst = 1'b1;
      @(negedge clk);
      check_value("post_rst_wrCount", {16'd0, wrc1}, 32'd0);
      read_word(18'h00005);
      check_value("post_rst_rdCount", {16'd0, rdc1}, 32'd1);
      check_value("sb_empty", sb_q.size(), 32'd0);

      // READ_LAT=1 instance: direct drive, then rdCount wrap by re-addressing every edge.
      rst2 = 1'b1;
      @(negedge clk);
      bus2.memEnable = 1'b0; bus2.memWrite = 1'b0; bus2.memRead = 1'b1;
      bus2.memAddrBus = 18'h0; drv2 = 1'b1; wdat2 = 16'hC0DE;
      @(negedge clk);
      bus2.memAddrBus = 18'h1; wdat2 = 16'hC0DF;
      @(negedge clk);
      drv2 = 1'b0;
      bus2.memWrite = 1'b1; bus2.memRead = 1'b0; bus2.memAddrBus = 18'h0;
      @(negedge clk);
      check_value("lat1_drive", {31'd0, bd2}, 32'd1);
      check_value("lat1_data", {16'd0, data2}, 32'h0000C0DE);
      check_value("lat1_rdCount", {16'd0, rdc2}, 32'd1);
      for (int i = 1; i < 65535; i++) begin
         bus2.memAddrBus = 18'(i & 1);
         @(negedge clk);
      end
      check_value("wrap_rdCount_ffff", {16'd0, rdc2}, 32'h0000FFFF);
      check_value("wrap_data_even", {16'd0, data2}, 32'h0000C0DE);
      bus2.memAddrBus = 18'h1;
      @(negedge clk);
      check_value("wrap_rdCount_zero", {16'd0, rdc2}, 32'd0);
      check_value("wrap_data_odd", {16'd0, data2}, 32'h0000C0DF);
      check_value("wrap_wrCount", {16'd0, wrc2}, 32'd2);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation exceeded time limit, got %0d cycles, expected fewer", cyc);
      $fatal(1, "watchdog expired");
   end

endmodule

// File: doc/sram_responder.md
SRAM_RESPONDER -- requirements
Module: sram_responder

Interface
REQ-001 SHALL have parameter DEPTH_LOG2, default 10, meaning number of address LSBs decoded (array holds 2^DEPTH_LOG2 x 16-bit words).
REQ-002 SHALL have parameter READ_LAT, default 2, legal range 1..7, meaning number of clock edges from read-request sample to data driven on the bus.
REQ-003 SHALL have port clk, input, 1 bit: single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit: reset, asynchronous, active-low.
REQ-005 SHALL have port memDataBus, inout, 16 bits: shared data bus; driven only while in RD_DRIVE, otherwise high-Z.
REQ-006 SHALL have port memAddrBus, input, 18 bits: word address from the memory controller.
REQ-007 SHALL have port memRead, input, 1 bit: output-enable, active-low.
REQ-008 SHALL have port memWrite, input, 1 bit: write-enable, active-low.
REQ-009 SHALL have port memEnable, input, 1 bit: chip-enable, active-low.
REQ-010 SHALL have port busDrive, output, 1 bit: high exactly while memDataBus is driven.
REQ-011 SHALL have port errFlag, output, 1 bit: sticky protocol-error indicator.
REQ-012 SHALL have port rdCount, output, 16 bits: completed read accesses, wraps modulo 2^16.
REQ-013 SHALL have port wrCount, output, 16 bits: committed write cycles, wraps modulo 2^16.

Function
REQ-014 SHALL sample memEnable, memRead, memWrite and memAddrBus on every rising clk edge; no combinational path from controls to memDataBus other than through busDrive state.
REQ-015 SHALL decode only memAddrBus[DEPTH_LOG2-1:0]; upper bits ignored (aliasing).
REQ-016 SHALL implement FSM states IDLE, RD_WAIT, RD_DRIVE, WRITE.
REQ-017 SHALL go IDLE->RD_WAIT on a sample with memEnable=0, memRead=0, memWrite=1, latching the address and loading the latency counter with READ_LAT-1.
REQ-018 SHALL go RD_WAIT->RD_DRIVE when the counter is 0; for READ_LAT=1 the transition is IDLE->RD_DRIVE directly, so data appears exactly READ_LAT edges after the request sample.
REQ-019 SHALL, in RD_DRIVE, drive mem[latched address] on memDataBus and increment rdCount once on entry.
REQ-020 SHALL, in RD_WAIT or RD_DRIVE, restart at RD_WAIT (READ_LAT=1: stay/re-enter RD_DRIVE) with the new address when a sample shows the read still asserted but the address changed; rdCount counts each entry into RD_DRIVE.
REQ-021 SHALL return to IDLE and release the bus on the first edge sampling memEnable=1 or memRead=1.
REQ-022 SHALL, from any state, go to WRITE on a sample with memEnable=0, memWrite=0; bus released on that edge.
REQ-023 SHALL, in WRITE, commit memDataBus to mem[memAddrBus] on every edge sampling memEnable=0, memWrite=0, increment wrCount per commit; last commit wins.
REQ-024 SHALL leave WRITE to IDLE on the first edge sampling memWrite=1 or memEnable=1; a simultaneous valid read request goes directly to RD_WAIT.
REQ-025 SHALL treat memRead=0 and memWrite=0 with memEnable=0 as a write (write has priority), never drive the bus, and set errFlag.
REQ-026 SHALL hold errFlag at 1 until reset.
REQ-027 SHALL ignore all controls while memEnable=1 (no commits, no counter changes).

Reset
REQ-028 SHALL, while rst=0, force state IDLE, memDataBus high-Z, busDrive=0, errFlag=0, rdCount=0, wrCount=0, asynchronously, including mid-read or mid-write.
REQ-029 SHALL NOT clear memory array contents on reset; a write edge coinciding with rst=0 is not committed.

Verification
REQ-030 Write 0xBEEF to addr 0x00005 (one cycle, enable+write low), then read addr 0x00005 -> bus high-Z for READ_LAT-1 cycles, 0xBEEF driven READ_LAT edges after request sample, busDrive=1, wrCount=1, rdCount=1.
REQ-031 Read addr 0x00405 with DEPTH_LOG2=10 after writing 0x1234 to 0x00005 -> returns 0x1234 (aliasing).
REQ-032 Hold read, change address mid-RD_DRIVE from 0x10 to 0x11 -> bus released/stale data replaced, new word valid READ_LAT edges after the change, rdCount increments by 1.
REQ-033 Assert memRead=0 and memWrite=0 with memEnable=0, data 0xA5A5 at addr 0x20 -> bus never driven, mem[0x20]=0xA5A5, errFlag=1 and stays 1 after controls idle.
REQ-034 Assert rst=0 while in RD_DRIVE -> bus high-Z and counters/errFlag zero immediately without clock; previously written data still readable after reset release.
REQ-035 Issue 65536 read accesses -> rdCount wraps to 0x0000.
